collision_engine: RTL

COLLISION_ENGINE -- requirements
Module: collision_engine

---
 rtl/collision_pkg.sv | 17 +
 rtl/collision_obj_fsm.sv | 91 +++++++++
 rtl/collision_engine.sv | 65 ++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types and limits for the collision engine: per-object FSM states,
// pulse-mode selectors and legal parameter bounds.
package collision_pkg;

  typedef enum logic [1:0] {
    ARMED,
    PENDING,
    FIRED,
    HOLDOFF
  } obj_state_e;

  localparam int PULSE_IMMEDIATE = 0;
  localparam int PULSE_SUMMARY   = 1;
  localparam int MAX_OBJ         = 32;
  localparam int MAX_HOLDOFF     = 255;

endpackage

// File: rtl/collision_obj_fsm.sv
// One object's hit FSM: pulse generation, holdoff frame counter and the
// per-frame hit accumulator.
module collision_obj_fsm
  import collision_pkg::*;
#(
  parameter int PULSE_MODE     = PULSE_IMMEDIATE,
  parameter int HOLDOFF_FRAMES = 0
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic raw,
  output logic hit_pulse,
  output logic frame_hit,
  output logic holdoff_active
);

  localparam int CW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLDOFF_FRAMES);

  obj_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          pulse_q, pulse_d;
  logic          fhit_q, fhit_d;
  logic          hoff_q, hoff_d;
  logic          eof;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    eof     = 1'b0;
    unique case (state_q)
      ARMED: if (raw) begin
        // A hit landing on startOfFrame belongs to the frame that is ending.
        state_d = (PULSE_MODE == PULSE_IMMEDIATE) ? FIRED : PENDING;
        pulse_d = (PULSE_MODE == PULSE_IMMEDIATE) || sof;
        eof     = sof;
      end
      PENDING: if (sof) begin
        pulse_d = 1'b1;
        eof     = 1'b1;
      end
      FIRED: eof = sof;
      HOLDOFF: if (sof) begin
        if (cnt_q <= CW'(1)) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ARMED;
    endcase
    if (eof) begin
      if (HOLDOFF_FRAMES == 0) begin
        state_d = ARMED;
      end else begin
        state_d = HOLDOFF;
        cnt_d   = HOLD_INIT;
      end
    end
    acc_d  = sof ? 1'b0 : (acc_q | raw);
    fhit_d = sof ? (acc_q | raw) : fhit_q;
    hoff_d = (state_d == HOLDOFF);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      pulse_q <= 1'b0;
      fhit_q  <= 1'b0;
      hoff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
      fhit_q  <= fhit_d;
      hoff_q  <= hoff_d;
    end
  end

  assign hit_pulse      = pulse_q;
  assign frame_hit      = fhit_q;
  assign holdoff_active = hoff_q;

endmodule

// File: rtl/collision_engine.sv
// Per-pixel sprite collision detector: mask-qualified overlap per object,
// registered collision level and one hit FSM per object.
module collision_engine
  import collision_pkg::*;
#(
  parameter int                         NUM_OBJ        = 8,
  parameter logic [NUM_OBJ*NUM_OBJ-1:0] COLLIDE_MASK   = '1,
  parameter int                         PULSE_MODE     = PULSE_IMMEDIATE,
  parameter int                         HOLDOFF_FRAMES = 0
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_OBJ-1:0] draw_req,
  input  logic [NUM_OBJ-1:0] inhibit,
  output logic [NUM_OBJ-1:0] collide_now,
  output logic [NUM_OBJ-1:0] hit_pulse,
  output logic [NUM_OBJ-1:0] frame_hits,
  output logic [NUM_OBJ-1:0] holdoff_active
);

  if (NUM_OBJ < 2 || NUM_OBJ > MAX_OBJ) begin : g_bad_num_obj
    $error("collision_engine: NUM_OBJ out of range 2..32");
  end
  if (HOLDOFF_FRAMES < 0 || HOLDOFF_FRAMES > MAX_HOLDOFF) begin : g_bad_holdoff
    $error("collision_engine: HOLDOFF_FRAMES out of range 0..255");
  end
  if (PULSE_MODE != PULSE_IMMEDIATE && PULSE_MODE != PULSE_SUMMARY) begin : g_bad_mode
    $error("collision_engine: PULSE_MODE must be 0 or 1");
  end

  logic [NUM_OBJ-1:0] raw;
  logic [NUM_OBJ-1:0] collide_now_q, collide_now_d;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    // Row g lists the objects that can hit object g; an object never hits itself.
    localparam logic [NUM_OBJ-1:0] ROW =
      COLLIDE_MASK[g*NUM_OBJ +: NUM_OBJ] & ~(NUM_OBJ'(1) << g);

    assign raw[g] = draw_req[g] & (|(draw_req & ROW)) & ~inhibit[g];

    collision_obj_fsm #(
      .PULSE_MODE     (PULSE_MODE),
      .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
    ) u_fsm (
      .clk            (clk),
      .resetN         (resetN),
      .sof            (startOfFrame),
      .raw            (raw[g]),
      .hit_pulse      (hit_pulse[g]),
      .frame_hit      (frame_hits[g]),
      .holdoff_active (holdoff_active[g])
    );
  end

  always_comb collide_now_d = raw;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) collide_now_q <= '0;
    else         collide_now_q <= collide_now_d;
  end

  assign collide_now = collide_now_q;

endmodule
